// File: rtl/datapath_pkg.sv
// Shared types and constants for the multi-cycle datapath: FSM states, ALU opcodes,
// status flag positions and control-word field offsets.
package datapath_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam int unsigned FS_ADD   = 0;
  localparam int unsigned FS_SUB   = 1;
  localparam int unsigned FS_AND   = 2;
  localparam int unsigned FS_OR    = 3;
  localparam int unsigned FS_XOR   = 4;
  localparam int unsigned FS_NOR   = 5;
  localparam int unsigned FS_PASSA = 6;
  localparam int unsigned FS_PASSB = 7;
  localparam int unsigned FS_SHL   = 8;
  localparam int unsigned FS_SHR   = 9;
  localparam int unsigned FS_ASR   = 10;

  localparam int ST_N = 0;
  localparam int ST_Z = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  // Single-bit control fields sit at the bottom of the control word, FS above them,
  // then SB, SA, DA and PS; the register-index offsets depend on the module widths.
  localparam int CW_SL     = 0;
  localparam int CW_PCSEL  = 1;
  localparam int CW_SELB   = 2;
  localparam int CW_EN_PC  = 3;
  localparam int CW_EN_B   = 4;
  localparam int CW_EN_ALU = 5;
  localparam int CW_EN_MEM = 6;
  localparam int CW_RAMW   = 7;
  localparam int CW_REGW   = 8;
  localparam int CW_FS_LSB = 9;

  function automatic int cw_width(input int reg_addr_w, input int fs_w);
    return 2 + 3 * reg_addr_w + fs_w + 9;
  endfunction

endpackage

// File: rtl/datapath_core_mc_alu.sv
// Combinational ALU for the multi-cycle datapath; produces the result and {V,C,Z,N}.
module alu_core
  import datapath_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int FS_W   = 5
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [FS_W-1:0]   fs_i,
  output logic [DATA_W-1:0] result_o,
  output logic [3:0]        flags_o
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MSB  = DATA_W - 1;

  logic signed [DATA_W-1:0] a_s;
  logic [DATA_W:0]          sum;
  logic [DATA_W-1:0]        res;
  logic [SH_W-1:0]          sh;
  logic                     c;
  logic                     v;

  assign a_s = $signed(a_i);
  assign sh  = b_i[SH_W-1:0];

  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (fs_i)
      FS_W'(FS_ADD): begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
      end
      // Carry on subtract means "no borrow" (A >= B unsigned).
      FS_W'(FS_SUB): begin
        sum = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_W + 1)'(1);
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
      end
      FS_W'(FS_AND):   res = a_i & b_i;
      FS_W'(FS_OR):    res = a_i | b_i;
      FS_W'(FS_XOR):   res = a_i ^ b_i;
      FS_W'(FS_NOR):   res = ~(a_i | b_i);
      FS_W'(FS_PASSA): res = a_i;
      FS_W'(FS_PASSB): res = b_i;
      FS_W'(FS_SHL):   res = a_i << sh;
      FS_W'(FS_SHR):   res = a_i >> sh;
      FS_W'(FS_ASR):   res = a_s >>> sh;
      default:         res = '0;
    endcase
  end

  assign result_o = res;
  assign flags_o  = {v, c, (res == '0), res[MSB]};

endmodule

// File: rtl/datapath_core_mc.sv
// Multi-cycle register-file/ALU datapath: IDLE -> EXEC -> [MEM] -> WB with a req/ack memory port.
// Optional feature macro DATAPATH_OVERLAP_EN: also accept the next control word while in WB.
module datapath_core_mc
  import datapath_pkg::*;
#(
  parameter int  DATA_W      = 64,
  parameter int  REG_ADDR_W  = 5,
  parameter int  FS_W        = 5,
  parameter int  MEM_TIMEOUT = 16,
  localparam int CW_W        = cw_width(REG_ADDR_W, FS_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cw_valid,
  output logic              cw_ready,
  input  logic [CW_W-1:0]   control_word,
  input  logic [DATA_W-1:0] K,
  input  logic [DATA_W-1:0] PC4,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] PCin,
  output logic              pc_valid,
  output logic [1:0]        PS,
  output logic [4:0]        statusOut,
  output logic              mem_err
);

  localparam int REG_CNT = 2 ** REG_ADDR_W;
  localparam int SB_LSB  = CW_FS_LSB + FS_W;
  localparam int SA_LSB  = SB_LSB + REG_ADDR_W;
  localparam int DA_LSB  = SA_LSB + REG_ADDR_W;
  localparam int PS_LSB  = DA_LSB + REG_ADDR_W;
  localparam int TMO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(REG_CNT - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic [DATA_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0]   pc4_q, pc4_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   pcin_q, pcin_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          status_q, status_d;
  logic                mem_err_q, mem_err_d;
  logic                abort_q, abort_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W-1:0]   rf_q [REG_CNT];

  logic [REG_ADDR_W-1:0] cw_da, cw_sa, cw_sb;
  logic [FS_W-1:0]       cw_fs;
  logic                  f_regw, f_ramw, f_en_mem, f_en_alu, f_en_b, f_en_pc;
  logic                  f_selb, f_pcsel, f_sl;
  logic [DATA_W-1:0]     rd_a, rd_b, bmux, alu_res, wb_val;
  logic [3:0]            alu_flags;
  logic                  accept, rf_we;

  assign cw_da    = cw_q[DA_LSB +: REG_ADDR_W];
  assign cw_sa    = cw_q[SA_LSB +: REG_ADDR_W];
  assign cw_sb    = cw_q[SB_LSB +: REG_ADDR_W];
  assign cw_fs    = cw_q[CW_FS_LSB +: FS_W];
  assign f_regw   = cw_q[CW_REGW];
  assign f_ramw   = cw_q[CW_RAMW];
  assign f_en_mem = cw_q[CW_EN_MEM];
  assign f_en_alu = cw_q[CW_EN_ALU];
  assign f_en_b   = cw_q[CW_EN_B];
  assign f_en_pc  = cw_q[CW_EN_PC];
  assign f_selb   = cw_q[CW_SELB];
  assign f_pcsel  = cw_q[CW_PCSEL];
  assign f_sl     = cw_q[CW_SL];

`ifdef DATAPATH_OVERLAP_EN
  assign cw_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
`else
  assign cw_ready = (state_q == ST_IDLE);
`endif
  assign accept = cw_valid && cw_ready;

  // The top register is hard-wired to zero on read.
  assign rd_a = (cw_sa == REG_ZERO) ? '0 : rf_q[cw_sa];
  assign rd_b = (cw_sb == REG_ZERO) ? '0 : rf_q[cw_sb];
  assign bmux = f_selb ? k_q : rd_b;

  alu_core #(.DATA_W(DATA_W), .FS_W(FS_W)) u_alu (
    .a_i      (rd_a),
    .b_i      (bmux),
    .fs_i     (cw_fs),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  always_comb begin
    if (f_en_mem)      wb_val = rdata_q;
    else if (f_en_alu) wb_val = result_q;
    else if (f_en_b)   wb_val = b_q;
    else if (f_en_pc)  wb_val = pc4_q;
    else               wb_val = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    k_d       = k_q;
    pc4_d     = pc4_q;
    result_d  = result_q;
    flags_d   = flags_q;
    b_d       = b_q;
    pcin_d    = pcin_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    mem_err_d = mem_err_q;
    abort_d   = abort_q;
    tmo_d     = tmo_q;
    rf_we     = 1'b0;
    if (accept) begin
      cw_d  = control_word;
      k_d   = K;
      pc4_d = PC4;
    end
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        result_d = alu_res;
        flags_d  = alu_flags;
        b_d      = rd_b;
        pcin_d   = f_pcsel ? k_q : rd_a;
        abort_d  = 1'b0;
        tmo_d    = '0;
        state_d  = (f_ramw || f_en_mem) ? ST_MEM : ST_WB;
      end
      // An ack arriving in the expiry cycle still wins over the timeout.
      ST_MEM: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = ST_WB;
        end else if (tmo_q == TMO_LAST) begin
          mem_err_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = ST_WB;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        rf_we = f_regw && !abort_q && (cw_da != REG_ZERO);
        if (f_sl && !abort_q) status_d = flags_q;
        state_d = accept ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cw_q      <= '0;
      k_q       <= '0;
      pc4_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      b_q       <= '0;
      pcin_q    <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      mem_err_q <= 1'b0;
      abort_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      cw_q      <= cw_d;
      k_q       <= k_d;
      pc4_q     <= pc4_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      b_q       <= b_d;
      pcin_q    <= pcin_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      mem_err_q <= mem_err_d;
      abort_q   <= abort_d;
      tmo_q     <= tmo_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[cw_da] <= wb_val;
    end
  end

  assign mem_req   = (state_q == ST_MEM);
  assign mem_we    = mem_req && f_ramw;
  assign mem_addr  = result_q;
  assign mem_wdata = b_q;
  assign data_out  = (state_q == ST_WB) ? wb_val : '0;
  assign pc_valid  = (state_q == ST_WB);
  assign PCin      = pcin_q;
  assign PS        = cw_q[PS_LSB +: 2];
  assign statusOut = {status_q, flags_q[ST_Z]};
  assign mem_err   = mem_err_q;

endmodule
